// File: rtl/result_tx_4bit_if.sv
// Parallel-in / serial-out bus bundle for result_tx_4bit.
// The slave side is the transmitter: it takes the word handshake and drives
// the serial line plus the status flags.
interface result_tx_4bit_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             tx;
    logic             busy;
    logic             done;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  tx,
        input  busy,
        input  done
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output tx,
        output busy,
        output done
    );
endinterface

// File: rtl/result_tx_4bit.sv
// result_tx_4bit: UART-style serial transmitter for logic-unit result words.
// Frame: start (0), WIDTH data bits LSB first, optional even parity, stop (1).
// Each bit is held CLKS_PER_BIT clocks. All outputs are registered.
// Optional feature: define RESULT_TX_PARITY_EN to insert an even parity bit
// between the last data bit and the stop bit.
module result_tx_4bit #(
    parameter int WIDTH        = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    result_tx_4bit_if.slave bus
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] BIT_LAST = IW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef RESULT_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t           state_reg;
    logic [CW-1:0]    cnt_reg;
    logic [IW-1:0]    bit_idx_reg;
    logic [WIDTH-1:0] data_reg;
    logic             tx_reg;
    logic             in_ready_reg;
    logic             busy_reg;
    logic             done_reg;

    logic             bit_end;
    logic [IW-1:0]    bit_next;

    // Terminal count of the bit-period counter and the following data index.
    assign bit_end  = (cnt_reg == CNT_LAST);
    assign bit_next = bit_idx_reg + 1'b1;

    assign bus.tx       = tx_reg;
    assign bus.in_ready = in_ready_reg;
    assign bus.busy     = busy_reg;
    assign bus.done     = done_reg;

    // Frame sequencer: state, counters, latched word and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            bit_idx_reg  <= '0;
            data_reg     <= '0;
            tx_reg       <= 1'b1;
            in_ready_reg <= 1'b1;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            // done is a single-cycle pulse; only the STOP exit raises it.
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid && in_ready_reg) begin
                        data_reg     <= bus.in_data;
                        state_reg    <= START;
                        cnt_reg      <= '0;
                        bit_idx_reg  <= '0;
                        tx_reg       <= 1'b0;
                        in_ready_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        cnt_reg     <= '0;
                        bit_idx_reg <= '0;
                        state_reg   <= DATA;
                        tx_reg      <= data_reg[0];
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt_reg <= '0;
                        if (bit_idx_reg == BIT_LAST) begin
                            bit_idx_reg <= '0;
`ifdef RESULT_TX_PARITY_EN
                            state_reg   <= PARITY;
                            tx_reg      <= ^data_reg;
`else
                            state_reg   <= STOP;
                            tx_reg      <= 1'b1;
`endif
                        end else begin
                            bit_idx_reg <= bit_next;
                            tx_reg      <= data_reg[bit_next];
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
`ifdef RESULT_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        cnt_reg   <= '0;
                        state_reg <= STOP;
                        tx_reg    <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        cnt_reg      <= '0;
                        state_reg    <= IDLE;
                        tx_reg       <= 1'b1;
                        in_ready_reg <= 1'b1;
                        busy_reg     <= 1'b0;
                        done_reg     <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg    <= IDLE;
                    cnt_reg      <= '0;
                    tx_reg       <= 1'b1;
                    in_ready_reg <= 1'b1;
                    busy_reg     <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_result_tx_4bit.sv
// Testbench for result_tx_4bit: random words through a scoreboard, plus
// directed frames, mid-frame reset and a CLKS_PER_BIT=1 instance.
module tb_result_tx_4bit;
    localparam int W = 4;
    localparam int C = 4;
`ifdef RESULT_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int SLOTS = W + 2 + PAR;
    localparam int FRAME = SLOTS * C;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    result_tx_4bit_if #(.WIDTH(W)) bus ();
    result_tx_4bit_if #(.WIDTH(W)) bus1 ();

    result_tx_4bit #(.WIDTH(W), .CLKS_PER_BIT(C)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    result_tx_4bit #(.WIDTH(W), .CLKS_PER_BIT(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference frame: slot 0 start, slots 1..W data LSB first, parity, then stop.
    function automatic logic frame_bit(input logic [W-1:0] w, input int slot);
        if (slot == 0) return 1'b0;
        if (slot <= W) return w[slot-1];
        if (PAR == 1 && slot == W + 1) return ($countones(w) % 2) == 1;
        return 1'b1;
    endfunction

    // Acceptance model: a word is taken whenever the transmitter is free;
    // it is free again FRAME cycles after an acceptance (the done cycle).
    logic [W-1:0] exp_q[$];
    int  model_cnt = 0;
    bit  rst_at_edge = 1'b1;
    bit  seen_edge = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            rst_at_edge = 1'b1;
            model_cnt = 0;
            exp_q.delete();
        end else begin
            rst_at_edge = 1'b0;
            if (model_cnt == 0) begin
                if (bus.in_valid) begin
                    exp_q.push_back(bus.in_data);
                    model_cnt = FRAME;
                end
            end else begin
                model_cnt--;
            end
        end
        seen_edge = 1'b1;
    end

    // Monitor: pops an expected word when a frame is due and checks every cycle.
    bit           mon_active = 1'b0;
    bit           done_due = 1'b0;
    int           mon_cyc = 0;
    logic [W-1:0] mon_word = '0;

    always @(negedge clk) begin
        if (seen_edge) begin
            if (rst_at_edge) begin
                check("reset_out", {bus.tx, bus.in_ready, bus.busy, bus.done}, 4'b1100);
                mon_active = 1'b0;
                done_due = 1'b0;
            end else begin
                if (!mon_active && exp_q.size() > 0) begin
                    mon_word = exp_q.pop_front();
                    mon_active = 1'b1;
                    mon_cyc = 0;
                    $display("frame word=%0h", mon_word);
                end
                if (mon_active) begin
                    check($sformatf("tx_w%0h_c%0d", mon_word, mon_cyc), bus.tx,
                          frame_bit(mon_word, mon_cyc / C));
                    check("frame_status", {bus.in_ready, bus.busy, bus.done}, 3'b010);
                    mon_cyc++;
                    if (mon_cyc == FRAME) begin
                        mon_active = 1'b0;
                        done_due = 1'b1;
                    end
                end else begin
                    check("idle_status", {bus.tx, bus.in_ready, bus.busy, bus.done},
                          {3'b110, done_due});
                    done_due = 1'b0;
                end
            end
        end
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus1.in_valid = 1'b0;
        bus1.in_data = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed single frame 4'b1010
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data = 4'b1010;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (FRAME + 3) @(negedge clk);

        // Held valid: 4'h3 accepted, change to 4'h5 mid-frame must be ignored
        bus.in_valid = 1'b1;
        bus.in_data = 4'h3;
        @(negedge clk);
        bus.in_data = 4'h5;
        repeat (2 * FRAME + 1) @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2 * FRAME) @(negedge clk);

        // Reset during DATA bit 2, then a clean frame
        bus.in_valid = 1'b1;
        bus.in_data = 4'(($urandom & 32'hF));
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3 * C) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data = 4'hC;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (FRAME + 3) @(negedge clk);

        // Random traffic
        repeat (600) begin
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.in_data = 4'($urandom_range(0, 15));
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        repeat (2 * FRAME) @(negedge clk);
        check("drain", exp_q.size() + int'(mon_active), 0);

        // CLKS_PER_BIT=1 instance, word 4'hF
        check("cpb1_idle", {bus1.tx, bus1.in_ready, bus1.busy, bus1.done}, 4'b1100);
        bus1.in_valid = 1'b1;
        bus1.in_data = 4'hF;
        @(negedge clk);
        bus1.in_valid = 1'b0;
        for (int s = 0; s < SLOTS; s++) begin
            check($sformatf("cpb1_tx_s%0d", s), bus1.tx, frame_bit(4'hF, s));
            check("cpb1_busy", {bus1.in_ready, bus1.busy, bus1.done}, 3'b010);
            @(negedge clk);
        end
        check("cpb1_done", {bus1.tx, bus1.in_ready, bus1.busy, bus1.done}, 4'b1101);
        @(negedge clk);
        check("cpb1_after", {bus1.tx, bus1.in_ready, bus1.busy, bus1.done}, 4'b1100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
